// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_tx
// Purpose  : Packet transmitter feeding the 1x3 router input port. Buffers up
//            to MAX_LEN payload bytes, then frames them as header, payload
//            and parity bytes while honouring router back-pressure (busy).
//            Parity can be deliberately inverted to exercise the router's
//            error path.
// Revision : 1.0  initial release
// ============================================================================
module router_pkt_tx #(
   parameter int MAX_LEN = 63,
   parameter int GAP_CYC = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       start,
   input  logic [1:0] dst_addr,
   input  logic       inj_par_err,
   input  logic       busy,
   output logic [7:0] d_in,
   output logic       pkt_valid,
   output logic       tx_idle,
   output logic [6:0] buf_cnt,
   output logic       done,
   output logic       req_err
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_HEADER  = 3'd1;
   localparam logic [2:0] ST_PAYLOAD = 3'd2;
   localparam logic [2:0] ST_PARITY  = 3'd3;
   localparam logic [2:0] ST_GAP     = 3'd4;

   logic [2:0] r_state;
   logic [7:0] r_mem [0:MAX_LEN-1];
   logic [6:0] r_cnt;
   logic [5:0] r_len;
   logic [5:0] r_rd_idx;
   logic [7:0] r_par;
   logic       r_inj;
   logic [7:0] r_gap;
   logic [7:0] r_d_in;
   logic       r_pkt_valid;
   logic       r_done;
   logic       r_req_err;

   logic       w_wr_ok;
   logic       w_last;
   logic [7:0] w_par_next;

   // A write lands only while idle, without a simultaneous start, and while space remains.
   assign w_wr_ok    = (r_state == ST_IDLE) && wr_en && !start && (r_cnt < 7'(MAX_LEN));
   // The payload byte currently presented is the final one of the packet.
   assign w_last     = (r_rd_idx == r_len);
   // Running parity including the byte currently on d_in.
   assign w_par_next = r_par ^ r_d_in;

   // Payload storage; contents are meaningless once buf_cnt clears, so no reset.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_cnt[5:0]] <= wr_data;
      end
   end

   // Framing state machine; every output byte is registered so busy can hold it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 7'd0;
         r_len       <= 6'd0;
         r_rd_idx    <= 6'd0;
         r_par       <= 8'd0;
         r_inj       <= 1'b0;
         r_gap       <= 8'd0;
         r_d_in      <= 8'd0;
         r_pkt_valid <= 1'b0;
         r_done      <= 1'b0;
         r_req_err   <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_req_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (r_cnt == 7'd0) begin
                     r_req_err <= 1'b1;
                  end else if (dst_addr == 2'd3) begin
                     r_req_err <= 1'b1;
                     r_cnt     <= 7'd0;
                  end else begin
                     r_len       <= r_cnt[5:0];
                     r_inj       <= inj_par_err;
                     r_d_in      <= {r_cnt[5:0], dst_addr};
                     r_pkt_valid <= 1'b1;
                     r_state     <= ST_HEADER;
                  end
               end else if (w_wr_ok) begin
                  r_cnt <= r_cnt + 7'd1;
               end
            end
            ST_HEADER: begin
               if (!busy) begin
                  // Parity seeds from the header; a launched packet always has L >= 1.
                  r_par    <= r_d_in;
                  r_d_in   <= r_mem[0];
                  r_rd_idx <= 6'd1;
                  r_state  <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (!busy) begin
                  r_par <= w_par_next;
                  if (w_last) begin
                     r_d_in      <= w_par_next ^ {8{r_inj}};
                     r_pkt_valid <= 1'b0;
                     r_state     <= ST_PARITY;
                  end else begin
                     r_d_in   <= r_mem[r_rd_idx];
                     r_rd_idx <= r_rd_idx + 6'd1;
                  end
               end
            end
            ST_PARITY: begin
               if (!busy) begin
                  r_d_in  <= 8'd0;
                  r_done  <= 1'b1;
                  r_cnt   <= 7'd0;
                  r_gap   <= 8'(GAP_CYC - 1);
                  r_state <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (r_gap == 8'd0) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_gap <= r_gap - 8'd1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_d_in      <= 8'd0;
               r_pkt_valid <= 1'b0;
            end
         endcase
      end
   end

   assign d_in      = r_d_in;
   assign pkt_valid = r_pkt_valid;
   assign tx_idle   = (r_state == ST_IDLE);
   assign buf_cnt   = r_cnt;
   assign done      = r_done;
   assign req_err   = r_req_err;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_pkt_tx
// Purpose  : Self-checking bench for router_pkt_tx. A transaction-level model
//            (byte queue per packet) predicts every presented byte, the
//            done/gap timing and buffer occupancy under random back-pressure.
// Revision : 1.0  initial release
// ============================================================================
module tb_router_pkt_tx;

   localparam int MAX_LEN = 63;
   localparam int GAP_CYC = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'd0;
   logic       start = 1'b0;
   logic [1:0] dst_addr = 2'd0;
   logic       inj_par_err = 1'b0;
   logic       busy = 1'b0;
   logic [7:0] d_in;
   logic       pkt_valid;
   logic       tx_idle;
   logic [6:0] buf_cnt;
   logic       done;
   logic       req_err;

   int n_vec = 0;
   int n_err = 0;

   // Model of the payload buffer contents, in write order.
   logic [7:0] buf_q[$];

   router_pkt_tx #(.MAX_LEN(MAX_LEN), .GAP_CYC(GAP_CYC)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .start(start),
      .dst_addr(dst_addr), .inj_par_err(inj_par_err), .busy(busy),
      .d_in(d_in), .pkt_valid(pkt_valid), .tx_idle(tx_idle), .buf_cnt(buf_cnt),
      .done(done), .req_err(req_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One write attempt from IDLE; the model keeps at most MAX_LEN bytes.
   task automatic do_write(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      @(negedge clk);
      wr_en = 1'b0;
      if (buf_q.size() < MAX_LEN) buf_q.push_back(b);
      check("buf_cnt_wr", 32'(buf_cnt), 32'(buf_q.size()));
   endtask

   // A start that must be refused (empty buffer or address 3).
   task automatic do_reject(input logic [1:0] dst);
      start    = 1'b1;
      dst_addr = dst;
      @(negedge clk);
      start = 1'b0;
      if (dst == 2'd3) buf_q.delete();
      check("req_err_pulse", 32'(req_err), 32'd1);
      check("rej_pkt_valid", 32'(pkt_valid), 32'd0);
      check("rej_tx_idle", 32'(tx_idle), 32'd1);
      check("rej_buf_cnt", 32'(buf_cnt), 32'(buf_q.size()));
      @(negedge clk);
      check("req_err_end", 32'(req_err), 32'd0);
   endtask

   // mode 0: no busy; 1: random busy and stray start/wr_en; 2: busy for 2 cycles on payload byte 2.
   task automatic send_pkt(input logic [1:0] dst, input logic inj, input int mode);
      logic [7:0] q[$];
      logic [7:0] hdr;
      logic [7:0] par;
      logic       b;
      int         n;
      int         idx;
      int         bcnt;
      int         cyc;
      n   = buf_q.size();
      hdr = 8'((n * 4) + int'(dst));
      par = hdr;
      foreach (buf_q[i]) par = par ^ buf_q[i];
      if (inj) par = ~par;
      q.push_back(hdr);
      foreach (buf_q[i]) q.push_back(buf_q[i]);
      q.push_back(par);

      start       = 1'b1;
      dst_addr    = dst;
      inj_par_err = inj;
      wr_en       = (mode == 1) ? 1'($urandom % 2) : 1'b0;
      wr_data     = 8'($urandom);
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;

      idx = 0; bcnt = 0; cyc = 0;
      while (idx < q.size() && cyc < 1000) begin
         check("d_in", 32'(d_in), 32'(q[idx]));
         check("pkt_valid", 32'(pkt_valid), (idx < q.size() - 1) ? 32'd1 : 32'd0);
         check("tx_idle_busy", 32'(tx_idle), 32'd0);
         check("done_early", 32'(done), 32'd0);
         check("req_err_in_pkt", 32'(req_err), 32'd0);
         case (mode)
            1:       b = ($urandom % 4) == 0;
            2:       b = (idx == 2) && (bcnt < 2);
            default: b = 1'b0;
         endcase
         busy  = b;
         start = (mode == 1) ? (($urandom % 8) == 0) : 1'b0;
         dst_addr = 2'($urandom % 4);
         wr_en = (mode == 1) ? 1'($urandom % 2) : 1'b0;
         if (b) bcnt++;
         @(negedge clk);
         if (!b) idx++;
         cyc++;
      end
      busy = 1'b0; start = 1'b0; wr_en = 1'b0;
      if (cyc >= 1000) check("pkt_timeout", 32'd1, 32'd0);
      check("pkt_cycles", 32'(cyc), 32'(q.size() + bcnt));
      buf_q.delete();
      check("done_pulse", 32'(done), 32'd1);
      check("gap_d_in", 32'(d_in), 32'd0);
      check("gap_pkt_valid", 32'(pkt_valid), 32'd0);
      check("gap_buf_cnt", 32'(buf_cnt), 32'd0);
      check("gap_tx_idle", 32'(tx_idle), 32'd0);
      repeat (GAP_CYC) @(negedge clk);
      check("done_end", 32'(done), 32'd0);
      check("back_idle", 32'(tx_idle), 32'd1);
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk);
      check("rst_d_in", 32'(d_in), 32'd0);
      check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
      check("rst_tx_idle", 32'(tx_idle), 32'd1);
      check("rst_buf_cnt", 32'(buf_cnt), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_req_err", 32'(req_err), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Basic 3-byte packet, then with back-pressure on 0x22.
      do_write(8'h11); do_write(8'h22); do_write(8'h33);
      send_pkt(2'd1, 1'b0, 0);
      do_write(8'h11); do_write(8'h22); do_write(8'h33);
      send_pkt(2'd1, 1'b0, 2);

      // Rejected starts.
      do_reject(2'd0);
      do_write(8'hA5); do_write(8'h5A);
      do_reject(2'd3);

      // Overfill: 64 writes, last one dropped.
      for (int i = 0; i < 64; i++) do_write(8'(i));
      check("full_cnt", 32'(buf_cnt), 32'd63);
      send_pkt(2'd2, 1'b0, 0);

      // Inverted parity.
      do_write(8'h11); do_write(8'h22); do_write(8'h33);
      send_pkt(2'd1, 1'b1, 0);

      // Reset during the second payload byte.
      do_write(8'h11); do_write(8'h22); do_write(8'h33);
      start = 1'b1; dst_addr = 2'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_rst_d_in", 32'(d_in), 32'h22);
      #2 rst = 1'b0;
      #1;
      check("async_pkt_valid", 32'(pkt_valid), 32'd0);
      check("async_d_in", 32'(d_in), 32'd0);
      check("async_tx_idle", 32'(tx_idle), 32'd1);
      buf_q.delete();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("post_rst_done", 32'(done), 32'd0);
         check("post_rst_idle", 32'(tx_idle), 32'd1);
         check("post_rst_cnt", 32'(buf_cnt), 32'd0);
      end

      // Randomized packets with random back-pressure.
      for (int p = 0; p < 20; p++) begin
         n = 1 + int'($urandom % MAX_LEN);
         for (int i = 0; i < n; i++) do_write(8'($urandom));
         send_pkt(2'($urandom % 3), 1'($urandom % 2), 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter for the 1x3 router's input port. It buffers up to 63 payload bytes and frames them as header, payload and parity bytes. It drives the router's `d_in`/`pkt_valid` inputs and honours the router's `busy` back-pressure. It sits between the test/host stimulus logic and the router input, and can deliberately corrupt parity to exercise the router's `err` path.

## Interface
- `MAX_LEN`, 63: payload buffer depth and maximum packet length in bytes (fits the 6-bit header length field).
- `GAP_CYC`, 1: minimum idle cycles with `pkt_valid`=0 after a parity byte before the next header.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  write `wr_data` into the payload buffer.
- `wr_data`  in  8  payload byte.
- `start`  in  1  launch a packet from the buffered bytes.
- `dst_addr`  in  2  destination port 0..2, sampled with `start`.
- `inj_par_err`  in  1  sampled with `start`; when 1, the transmitted parity byte is inverted.
- `busy`  in  1  router back-pressure; when 1, the current byte is not accepted.
- `d_in`  out  8  byte to router.
- `pkt_valid`  out  1  high during header and payload bytes.
- `tx_idle`  out  1  high in IDLE; `start` and `wr_en` are accepted only while high.
- `buf_cnt`  out  7  number of bytes in the buffer, 0..63.
- `done`  out  1  one-cycle pulse after the parity byte is accepted.
- `req_err`  out  1  one-cycle pulse when a `start` is rejected.

## Operation
- States: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- **Buffer writes:** accepted in IDLE when `wr_en`=1, `start`=0 and `buf_cnt`<`MAX_LEN`. Otherwise the write is silently dropped. This includes a `wr_en` in the same cycle as `start`.
- **`start` in IDLE with `buf_cnt`=0:** `req_err` pulses and the block stays in IDLE.
- **`start` in IDLE with `dst_addr`=3:** `req_err` pulses, the buffer is cleared, and the block stays in IDLE.
- **Accepted `start`:** latches L=`buf_cnt`, the address and `inj_par_err`, then enters HEADER.
- **HEADER:** `d_in`={L[5:0], addr[1:0]}, `pkt_valid`=1.
- **PAYLOAD:** `d_in`=buffer bytes in write order, `pkt_valid`=1, for L accepted bytes.
- **PARITY:** `d_in`=P, `pkt_valid`=0.
  - P = XOR of the header and all payload bytes.
  - P is inverted (~P) if `inj_par_err` was latched.
- **Byte acceptance:** a byte is accepted at a rising edge where `busy`=0. While `busy`=1, `d_in`, `pkt_valid` and the state are held unchanged.
- **GAP:** entered after the parity byte is accepted.
  - `done` pulses in the first GAP cycle.
  - `buf_cnt` clears to 0 on entry.
  - After `GAP_CYC` cycles, the block returns to IDLE.
- **Idle outputs:** `d_in`=0 in IDLE and GAP.
- **`start` outside IDLE:** ignored, with no `req_err`.
- **Reset:** asynchronous, active-low.
  - Any time `rst`=0: state=IDLE, `d_in`=0, `pkt_valid`=0, `done`=0, `req_err`=0, `buf_cnt`=0.
  - `tx_idle` reads 1 during reset.
  - A reset mid-packet abandons the packet; no parity byte and no `done` are produced.

## Timing
- With `start` sampled at edge N and `busy`=0 throughout:
  - header in cycle N+1;
  - payload bytes in cycles N+2 .. N+1+L;
  - parity in cycle N+2+L;
  - `done` in cycle N+3+L;
  - `tx_idle`=1 from cycle N+3+L+`GAP_CYC`.
- Each cycle of `busy`=1 while a byte is presented extends the packet by exactly one cycle.
- `req_err` is asserted in the cycle after the rejected `start`.
- `buf_cnt` updates in the cycle after a write.
- `pkt_valid` falls in the same cycle the parity byte appears, never earlier.

## Test plan
- Write 0x11, 0x22, 0x33, then `start` with `dst_addr`=1 and `busy`=0:
  - `d_in` sequence is 0x0D, 0x11, 0x22, 0x33 with `pkt_valid`=1;
  - then 0x0D with `pkt_valid`=0;
  - `done` pulses one cycle later; `buf_cnt` returns to 0.
- Same packet with `busy`=1 for 2 cycles while 0x22 is presented:
  - 0x22 is held for 3 cycles;
  - the sequence is otherwise unchanged and `done` arrives 2 cycles later than in the first test.
- `start` with an empty buffer, and `start` with `dst_addr`=3 after 2 writes:
  - `req_err` pulses in each case and `pkt_valid` stays 0;
  - after the second, `buf_cnt`=0.
- Write 64 bytes 0x00..0x3F:
  - `buf_cnt`=63 and 0x3F is dropped;
  - `start` with `dst_addr`=2 gives header 0xFE, then 63 payload bytes, then parity = XOR(0xFE, 0x00..0x3E).
- Repeat the first test with `inj_par_err`=1:
  - parity byte is 0xF2; all other bytes are unchanged.
- Assert `rst`=0 during the second payload byte:
  - `pkt_valid` and `d_in` go to 0 immediately with no clock edge required;
  - after release, `tx_idle`=1 and `buf_cnt`=0, and no `done` is seen.
